// File: rtl/serial_slave_rx_pkg.sv
// Shared definitions for the serial slave receiver.
//   ADDR_W_DEF / DATA_W_DEF / BURST_W_DEF : default widths of the top-level parameters
//   rx_state_e                            : receiver FSM state encoding
package serial_slave_rx_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;
    localparam int BURST_W_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR_RX  = 2'd1,
        ST_DATA_RX  = 2'd2,
        ST_RD_BURST = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_slave_rx_sipo_shift.sv
// Generic LSB-first serial-to-parallel shifter.
//   clk, reset : clock, async active-high reset
//   clear      : discard any partial word and restart the bit count
//   shift_en   : sample din on this edge
//   din        : serial input bit
//   word       : assembled word, complete in the cycle done is high
//   done       : high in the cycle whose edge samples the last bit
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The final bit is merged combinationally so the caller can capture the
    // whole word on the same edge that samples its MSB.
    assign word = {din, shreg_q[WIDTH-1:1]};

    // cnt_q counts the bits still to come after the current one; the owner
    // always clears before the first shift, so the reset value of zero is safe.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = CNT_LOAD;
        end else if (shift_en) begin
            shreg_d = word;
            if (cnt_q == '0) begin
                done  = 1'b1;
                cnt_d = CNT_LOAD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_slave_rx.sv
// Serial slave receiver: handshake, serial address/data reception, read and
// write bursts with address auto-increment, abort on master_valid drop.
//   clk, reset            : clock, async active-high reset
//   rx_addr, rx_data      : serial address / data lines, LSB first
//   master_valid          : master request, must stay high through a transaction
//   write_en, read_en     : transaction direction, sampled at handshake
//   burst_len             : extra beats after the first, sampled at handshake
//   slave_ready           : high while idle and able to accept a handshake
//   addr_out, addr_valid  : current beat address and its one-cycle pulse
//   data_out, data_valid  : last received write word and its one-cycle pulse
//   burst_count           : beats completed minus one in the current transaction
//   abort                 : one-cycle pulse when a transaction is abandoned
//
// state       | meaning
// ST_IDLE     | waiting for handshake (slave_ready high)
// ST_ADDR_RX  | shifting in the ADDR_W address bits
// ST_DATA_RX  | shifting in DATA_W-bit write words, back-to-back for bursts
// ST_RD_BURST | one address increment per cycle until burst_len reached
module serial_slave_rx
    import serial_slave_rx_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_addr,
    input  logic               rx_data,
    input  logic               master_valid,
    input  logic               write_en,
    input  logic               read_en,
    input  logic [BURST_W-1:0] burst_len,
    output logic               slave_ready,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               addr_valid,
    output logic               data_valid,
    output logic [BURST_W-1:0] burst_count,
    output logic               abort
);

    rx_state_e          state_q, state_d;
    logic               ready_q, ready_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               addr_vld_q, addr_vld_d;
    logic               data_vld_q, data_vld_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic               is_wr_q, is_wr_d;
    logic               abort_q, abort_d;

    logic               shift_clr;
    logic [ADDR_W-1:0]  addr_word;
    logic               addr_done;
    logic [DATA_W-1:0]  data_word;
    logic               data_done;
    logic [BURST_W-1:0] count_inc;

    assign count_inc = count_q + 1'b1;

    sipo_shift #(.WIDTH(ADDR_W)) u_addr_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (shift_clr),
        .shift_en (state_q == ST_ADDR_RX && master_valid),
        .din      (rx_addr),
        .word     (addr_word),
        .done     (addr_done)
    );

    sipo_shift #(.WIDTH(DATA_W)) u_data_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (shift_clr),
        .shift_en (state_q == ST_DATA_RX && master_valid),
        .din      (rx_data),
        .word     (data_word),
        .done     (data_done)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        count_d    = count_q;
        len_d      = len_q;
        is_wr_d    = is_wr_q;
        addr_vld_d = 1'b0;
        data_vld_d = 1'b0;
        abort_d    = 1'b0;
        shift_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ambiguous direction (neither or both) is simply not a handshake.
                if (ready_q && master_valid && (write_en ^ read_en)) begin
                    state_d   = ST_ADDR_RX;
                    is_wr_d   = write_en;
                    len_d     = burst_len;
                    count_d   = '0;
                    shift_clr = 1'b1;
                end
            end
            ST_ADDR_RX: begin
                if (addr_done) begin
                    addr_d     = addr_word;
                    addr_vld_d = 1'b1;
                    if (is_wr_q)
                        state_d = ST_DATA_RX;
                    else if (len_q == '0)
                        state_d = ST_IDLE;
                    else
                        state_d = ST_RD_BURST;
                end
            end
            ST_DATA_RX: begin
                if (data_done) begin
                    data_d     = data_word;
                    data_vld_d = 1'b1;
                    if (count_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d    = count_inc;
                        addr_d     = addr_q + 1'b1;
                        addr_vld_d = 1'b1;
                    end
                end
            end
            ST_RD_BURST: begin
                addr_d     = addr_q + 1'b1;
                count_d    = count_inc;
                addr_vld_d = 1'b1;
                if (count_inc == len_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A dropped master_valid overrides whatever the beat would have done.
        if (state_q != ST_IDLE && !master_valid) begin
            state_d    = ST_IDLE;
            addr_d     = addr_q;
            data_d     = data_q;
            count_d    = count_q;
            addr_vld_d = 1'b0;
            data_vld_d = 1'b0;
            abort_d    = 1'b1;
            shift_clr  = 1'b1;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            addr_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            count_q    <= '0;
            len_q      <= '0;
            is_wr_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            addr_vld_q <= addr_vld_d;
            data_vld_q <= data_vld_d;
            count_q    <= count_d;
            len_q      <= len_d;
            is_wr_q    <= is_wr_d;
            abort_q    <= abort_d;
        end
    end

    assign slave_ready = ready_q;
    assign addr_out    = addr_q;
    assign data_out    = data_q;
    assign addr_valid  = addr_vld_q;
    assign data_valid  = data_vld_q;
    assign burst_count = count_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_serial_slave_rx.sv
module tb_serial_slave_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_addr, rx_data, master_valid, write_en, read_en;
    logic [11:0] burst_len;
    logic        slave_ready, addr_valid, data_valid, abort;
    logic [11:0] addr_out, burst_count;
    logic [7:0]  data_out;

    serial_slave_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx_addr      (rx_addr),
        .rx_data      (rx_data),
        .master_valid (master_valid),
        .write_en     (write_en),
        .read_en      (read_en),
        .burst_len    (burst_len),
        .slave_ready  (slave_ready),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .addr_valid   (addr_valid),
        .data_valid   (data_valid),
        .burst_count  (burst_count),
        .abort        (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t addr_sb[$];
    exp_t data_sb[$];
    exp_t e_mon;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] wdata [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every valid pulse must match the next expected value and cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (addr_valid) begin
                if (addr_sb.size() == 0) begin
                    chk("addr_unexpected", addr_valid, 0);
                end else begin
                    e_mon = addr_sb.pop_front();
                    chk("addr_val", addr_out, e_mon.val);
                    chk("addr_cyc", cyc, e_mon.cyc);
                end
            end
            if (data_valid) begin
                if (data_sb.size() == 0) begin
                    chk("data_unexpected", data_valid, 0);
                end else begin
                    e_mon = data_sb.pop_front();
                    chk("data_val", data_out, e_mon.val);
                    chk("data_cyc", cyc, e_mon.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!slave_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!slave_ready) chk("ready_timeout", slave_ready, 1);
    endtask

    // Full transaction; stop_beat <= blen abandons the bench side mid-word of
    // that beat (master_valid left high) so the caller can inject a reset.
    task automatic txn(input bit wr, input logic [11:0] addr, input int blen, input int stop_beat);
        int   hs;
        exp_t e;
        wait_ready();
        master_valid = 1'b1;
        write_en     = wr;
        read_en      = !wr;
        burst_len    = 12'(blen);
        @(posedge clk);
        #1;
        hs = cyc;
        // First address is visible in the 13th cycle after the handshake edge.
        for (int k = 0; k <= blen; k++) begin
            if (!wr) begin
                e.val = 32'(12'(addr + 12'(k)));
                e.cyc = hs + 12 + k;
                addr_sb.push_back(e);
            end else begin
                if (k <= stop_beat) begin
                    e.val = 32'(12'(addr + 12'(k)));
                    e.cyc = hs + 12 + 8 * k;
                    addr_sb.push_back(e);
                end
                if (k < stop_beat) begin
                    e.val = 32'(wdata[k]);
                    e.cyc = hs + 20 + 8 * k;
                    data_sb.push_back(e);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rx_addr = addr[i];
        end
        if (wr) begin
            for (int b = 0; b <= blen; b++) begin
                if (b == stop_beat) begin
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        rx_data = wdata[b][i];
                    end
                    return;
                end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    rx_data = wdata[b][i];
                end
            end
        end else begin
            repeat (blen) @(negedge clk);
        end
        @(negedge clk);
        chk("ready_after_txn", slave_ready, 1);
        chk("burst_count_final", burst_count, 32'(blen));
        master_valid = 1'b0;
        write_en     = 1'b0;
        read_en      = 1'b0;
    endtask

    task automatic chk_drained();
        repeat (3) @(negedge clk);
        chk("sb_addr_left", addr_sb.size(), 0);
        chk("sb_data_left", data_sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] prev_addr;
        reset = 1'b1;
        rx_addr = 0; rx_data = 0; master_valid = 0; write_en = 0; read_en = 0;
        burst_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", slave_ready, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_count", burst_count, 0);
        chk("rst_pulses", {addr_valid, data_valid, abort}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", slave_ready, 1);

        // Single read
        txn(0, 12'hA5C, 0, 1);
        chk("rd_addr_hold", addr_out, 12'hA5C);
        chk_drained();

        // Single write
        wdata[0] = 8'h3C;
        txn(1, 12'h010, 0, 1);
        chk("wr_data_hold", data_out, 8'h3C);
        chk_drained();

        // Read burst across the address wrap
        txn(0, 12'hFFE, 3, 4);
        chk("rd_wrap_addr", addr_out, 12'h001);
        chk_drained();

        // Write burst
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        txn(1, 12'h100, 2, 3);
        chk("wrb_addr", addr_out, 12'h102);
        chk("wrb_data", data_out, 8'h33);
        chk_drained();

        // Ambiguous direction must not be taken as a handshake
        wait_ready();
        master_valid = 1; write_en = 1; read_en = 1;
        @(negedge clk);
        chk("both_en_ignored", slave_ready, 1);
        write_en = 0; read_en = 0;
        @(negedge clk);
        chk("no_en_ignored", slave_ready, 1);
        master_valid = 0;
        chk_drained();

        // Abort during address bit 5
        wait_ready();
        prev_addr = addr_out;
        master_valid = 1; read_en = 1; burst_len = '0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_addr = ~rx_addr;
        end
        @(negedge clk);
        master_valid = 0; read_en = 0;
        @(negedge clk);
        chk("abort_pulse", abort, 1);
        chk("abort_addr_hold", addr_out, 32'(prev_addr));
        chk("abort_idle", slave_ready, 1);
        @(negedge clk);
        chk("abort_one_cycle", abort, 0);
        chk_drained();

        // Randomised write bursts
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 8; k++) wdata[k] = 8'($urandom);
            txn(1, 12'($urandom), t + 1, t + 2);
            chk_drained();
        end

        // Reset in the middle of beat 2 of a 6-beat write burst
        for (int k = 0; k < 8; k++) wdata[k] = 8'(8'h40 + k);
        txn(1, 12'h200, 5, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_addr", addr_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_count", burst_count, 0);
        chk("mid_rst_ready", slave_ready, 0);
        chk("mid_rst_pulses", {addr_valid, data_valid, abort}, 0);
        master_valid = 0; write_en = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", slave_ready, 1);
        chk("sb_after_rst", addr_sb.size() + data_sb.size(), 0);

        txn(0, 12'h3C7, 0, 1);
        chk("post_rst_read", addr_out, 12'h3C7);
        chk_drained();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_slave_rx.md
SERIAL_SLAVE_RX -- requirements
Module: serial_slave_rx

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter BURST_W, default 12, meaning burst length and counter width.
REQ-004 Port clk  input  1  clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port rx_addr  input  1  serial address line, LSB first.
REQ-007 Port rx_data  input  1  serial data line, LSB first.
REQ-008 Port master_valid  input  1  master request/hold qualifier.
REQ-009 Port write_en  input  1  transaction is a write; sampled at handshake.
REQ-010 Port read_en  input  1  transaction is a read; sampled at handshake.
REQ-011 Port burst_len  input  BURST_W  extra beats after the first (0 means single beat); sampled at handshake.
REQ-012 Port slave_ready  output  1  registered; high only in IDLE.
REQ-013 Port addr_out  output  ADDR_W  current beat address.
REQ-014 Port data_out  output  DATA_W  last received write word.
REQ-015 Port addr_valid  output  1  one-cycle pulse when addr_out holds a new beat address.
REQ-016 Port data_valid  output  1  one-cycle pulse when data_out holds a new word.
REQ-017 Port burst_count  output  BURST_W  beats completed minus one in the current transaction.
REQ-018 Port abort  output  1  one-cycle pulse on transaction abort.

Function
REQ-019 Handshake SHALL be master_valid & slave_ready sampled at a rising edge in IDLE.
REQ-020 The FSM SHALL have states IDLE, ADDR_RX, DATA_RX, RD_BURST.
REQ-021 On handshake: latch write_en, read_en, burst_len; clear burst_count and bit counters; go ADDR_RX. If write_en and read_en are both 0 or both 1, the handshake SHALL be ignored and the state SHALL remain IDLE.
REQ-022 ADDR_RX: sample rx_addr at the N-th edge after the handshake edge into bit N-1, for N = 1..ADDR_W; at the ADDR_W-th edge load addr_out with the full word and pulse addr_valid the following cycle; addr_out SHALL not change mid-shift.
REQ-023 After ADDR_RX: write goes to DATA_RX; read with burst_len=0 goes to IDLE; read with burst_len>0 goes to RD_BURST.
REQ-024 DATA_RX: sample rx_data over DATA_W edges, LSB first; at the last edge load data_out and pulse data_valid the following cycle.
REQ-025 Write burst: after each data word, if burst_count==burst_len go IDLE; else increment burst_count and addr_out, pulse addr_valid, and receive the next word back-to-back in DATA_RX with no idle cycle.
REQ-026 RD_BURST: each cycle, increment addr_out, increment burst_count and pulse addr_valid; go IDLE in the cycle burst_count reaches burst_len.
REQ-027 addr_out increment SHALL wrap modulo 2^ADDR_W (all-ones to zero) without affecting burst_count.
REQ-028 master_valid low at any edge in ADDR_RX, DATA_RX or RD_BURST SHALL pulse abort, go IDLE, and discard any partial word with no valid pulse; addr_out and data_out SHALL hold their last completed values.
REQ-029 slave_ready SHALL be 1 in the cycle after entering IDLE and 0 in the cycle after leaving it; a new handshake SHALL NOT be accepted in the same cycle as a completion or an abort.
REQ-030 addr_valid and data_valid SHALL never be asserted for two consecutive cycles in DATA_RX, except that addr_valid and data_valid MAY coincide at a write-burst beat boundary.

Reset
REQ-031 Reset SHALL force IDLE, slave_ready=0 (1 from the first edge after release), and zero for addr_out, data_out, burst_count, addr_valid, data_valid, abort and all internal counters, including when reset is asserted mid-transaction.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default width constants (12/8/12).
REQ-033 A generic serial-to-parallel shifter sub-module, sipo_shift (parameter WIDTH; outputs word and done), SHALL be instantiated twice, once for address and once for data.

Verification
REQ-034 Single read: addr 0xA5C serial, read_en=1, burst_len=0 -> addr_out=0xA5C with one addr_valid pulse 13 cycles after the handshake; slave_ready back high.
REQ-035 Single write: addr 0x010, data 0x3C -> addr_out=0x010, then data_out=0x3C with one data_valid pulse 8 cycles after addr_valid.
REQ-036 Read burst with wrap: addr 0xFFE, burst_len=3 -> addr_valid on 4 consecutive cycles with addr_out 0xFFE, 0xFFF, 0x000, 0x001; final burst_count=3.
REQ-037 Write burst: addr 0x100, burst_len=2, data 0x11, 0x22, 0x33 -> data_valid x3 spaced 8 cycles apart; addr_out 0x100, 0x101, 0x102.
REQ-038 Abort: master_valid dropped at address bit 5 -> abort pulse, no addr_valid, addr_out unchanged, IDLE.
REQ-039 Reset mid-burst at beat 2 of burst_len=5 -> all outputs zero immediately; after reset release slave_ready=1 and a fresh single read completes correctly.
